// File: rtl/ahb_master_ctrl.sv
// rtl/ahb_master_ctrl.sv - AHB single-transfer initiator for register commands (optional AHB_MST_TIMEOUT_EN)
module ahb_master_ctrl #(
  parameter int         MAX_RETRY      = 4,
  parameter logic [3:0] HPROT_VAL      = 4'b0011,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t        state, state_nxt;
  logic          lat_write;
  logic [31:0]   lat_addr;
  logic [2:0]    lat_size;
  logic [31:0]   lat_wdata;
  logic [RW-1:0] retry_cnt;
  logic [31:0]   rdata_q;
  logic          error_q;

  logic          accept, retry_inc, rsp_load, rsp_err_d;
  logic [31:0]   rsp_rdata_d;
  logic          cmd_illegal;
  logic          to_hit;

  // Size/alignment legality of the command currently offered
  always_comb begin
    cmd_illegal = 1'b0;
    case (cmd_size)
      3'd0:    cmd_illegal = 1'b0;
      3'd1:    cmd_illegal = cmd_addr[0];
      3'd2:    cmd_illegal = |cmd_addr[1:0];
      default: cmd_illegal = 1'b1;
    endcase
  end

`ifdef AHB_MST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit = (state == S_ADDR || state == S_DATA) && !HREADY &&
                  (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Count consecutive stalled bus cycles; any ready cycle or leaving the bus phases clears it
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      to_cnt <= '0;
    else if ((state == S_ADDR || state == S_DATA) && !HREADY)
      to_cnt <= to_cnt + TW'(1);
    else
      to_cnt <= '0;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Next state and per-cycle actions from the current phase and slave response
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    retry_inc   = 1'b0;
    rsp_load    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_illegal) begin
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) state_nxt = S_DATA;
      end
      S_DATA: begin
        // A non-OKAY response with HREADY low is the first half of a two-cycle reply; just wait
        if (HREADY) begin
          case (HRESP)
            2'b00: begin
              rsp_load    = 1'b1;
              rsp_rdata_d = lat_write ? 32'd0 : HRDATA;
              state_nxt   = S_RESP;
            end
            2'b01: begin
              rsp_load  = 1'b1;
              rsp_err_d = 1'b1;
              state_nxt = S_RESP;
            end
            default: begin
              if (retry_cnt < RW'(MAX_RETRY)) begin
                retry_inc = 1'b1;
                state_nxt = S_ADDR;
              end else begin
                rsp_load  = 1'b1;
                rsp_err_d = 1'b1;
                state_nxt = S_RESP;
              end
            end
          endcase
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (to_hit) begin
      state_nxt   = S_RESP;
      rsp_load    = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
      retry_inc   = 1'b0;
    end
  end

  // Phase register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Command latch and retry counter; the bus is driven only from these
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_wdata <= '0;
      retry_cnt <= '0;
    end else if (accept) begin
      lat_write <= cmd_write;
      lat_addr  <= cmd_addr;
      lat_size  <= cmd_size;
      lat_wdata <= cmd_wdata;
      retry_cnt <= '0;
    end else if (retry_inc) begin
      retry_cnt <= retry_cnt + RW'(1);
    end
  end

  // Response holding registers presented during the completion pulse
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end else if (rsp_load) begin
      rdata_q <= rsp_rdata_d;
      error_q <= rsp_err_d;
    end else if (accept) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;
  assign HTRANS    = (state == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR     = lat_addr;
  assign HWRITE    = lat_write;
  assign HSIZE     = lat_size;
  assign HWDATA    = lat_wdata;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;

endmodule
